ifft4_serial_tx: RTL

- Transmit-side counterpart of the radix-4 FFT core: a 4-point inverse FFT for the OFDM modulator.
- Accepts 4 frequency-domain complex samples serially (k=0..3) over a valid/ready handshake.
- Computes one radix-4 inverse butterfly scaled by 1/4, then streams 4 time-domain samples (n=0..3) out over a valid/ready handshake with backpressure.
- Sits between the subcarrier mapper and the cyclic-prefix/DAC path.

---
 rtl/ifft4_serial_tx_if.sv | 30 +++
 rtl/ifft4_serial_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ifft4_serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifft4_serial_tx_if
//  Purpose  : Sample-in / sample-out valid-ready streams of the 4-point IFFT.
//  Revision : 1.0  initial release
// ============================================================================
interface ifft4_serial_tx_if #(
    parameter int DATA_W = 16
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_i;
    logic signed [DATA_W-1:0] in_q;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_i;
    logic signed [DATA_W-1:0] out_q;
    logic                     out_last;

    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  in_ready, out_valid, out_i, out_q, out_last
    );

    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output in_ready, out_valid, out_i, out_q, out_last
    );
endinterface
`default_nettype wire

// File: rtl/ifft4_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ifft4_serial_tx
//  Purpose  : Serial-in/serial-out 4-point inverse FFT (radix-4, scaled 1/4).
//  Revision : 1.0  initial release
// ============================================================================
module ifft4_serial_tx #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    ifft4_serial_tx_if.slave  bus,
    output logic              busy,
    output logic [1:0]        stateIFFT
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0] r_in_cnt;
    logic [1:0] r_out_cnt;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_busy;
    logic       w_in_fire;
    logic       w_out_fire;

    logic signed [DATA_W-1:0] r_xi [4];
    logic signed [DATA_W-1:0] r_xq [4];
    logic signed [DATA_W-1:0] r_yi [4];
    logic signed [DATA_W-1:0] r_yq [4];

    logic signed [DATA_W+1:0] w_ar [4];
    logic signed [DATA_W+1:0] w_ai [4];
    logic signed [DATA_W+1:0] w_fr [4];
    logic signed [DATA_W+1:0] w_fi [4];
    logic signed [DATA_W-1:0] w_yi [4];
    logic signed [DATA_W-1:0] w_yq [4];
    logic signed [DATA_W+1:0] w_s0r, w_s0i, w_s1r, w_s1i;
    logic signed [DATA_W+1:0] w_d0r, w_d0i, w_d1r, w_d1i;
    logic                     w_unused_lsb;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_in_cnt == 2'd3)) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready && (r_out_cnt == 2'd3)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_out_valid & bus.out_ready;

    // ------------------------------------------------------------------------
    // Input capture and output sequencing; 2-bit counters wrap 3 -> 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_cnt  <= 2'd0;
            r_out_cnt <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_xi[k] <= '0;
                r_xq[k] <= '0;
                r_yi[k] <= '0;
                r_yq[k] <= '0;
            end
        end else begin
            if (w_in_fire) begin
                r_xi[r_in_cnt] <= bus.in_i;
                r_xq[r_in_cnt] <= bus.in_q;
                r_in_cnt       <= r_in_cnt + 2'd1;
            end
            if (r_state == ST_CALC) begin
                for (int k = 0; k < 4; k++) begin
                    r_yi[k] <= w_yi[k];
                    r_yq[k] <= w_yq[k];
                end
            end
            if (w_out_fire) begin
                r_out_cnt <= r_out_cnt + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Radix-4 inverse butterfly. Four DATA_W terms fit in DATA_W+2 bits and
    // the scaled result always fits DATA_W, so dropping the two LSBs is an
    // exact floor divide by 4.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_ar[k] = {{2{r_xi[k][DATA_W-1]}}, r_xi[k]};
            w_ai[k] = {{2{r_xq[k][DATA_W-1]}}, r_xq[k]};
        end
        w_s0r = w_ar[0] + w_ar[2];
        w_s0i = w_ai[0] + w_ai[2];
        w_d0r = w_ar[0] - w_ar[2];
        w_d0i = w_ai[0] - w_ai[2];
        w_s1r = w_ar[1] + w_ar[3];
        w_s1i = w_ai[1] + w_ai[3];
        w_d1r = w_ar[1] - w_ar[3];
        w_d1i = w_ai[1] - w_ai[3];

        // x1 = d0 + j*d1, x3 = d0 - j*d1, with j(a+jb) = -b+ja
        w_fr[0] = w_s0r + w_s1r;
        w_fi[0] = w_s0i + w_s1i;
        w_fr[1] = w_d0r - w_d1i;
        w_fi[1] = w_d0i + w_d1r;
        w_fr[2] = w_s0r - w_s1r;
        w_fi[2] = w_s0i - w_s1i;
        w_fr[3] = w_d0r + w_d1i;
        w_fi[3] = w_d0i - w_d1r;

        w_unused_lsb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_yi[k]      = w_fr[k][DATA_W+1:2];
            w_yq[k]      = w_fi[k][DATA_W+1:2];
            w_unused_lsb = w_unused_lsb ^ (^{w_fr[k][1:0], w_fi[k][1:0]});
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_i     = r_yi[r_out_cnt];
    assign bus.out_q     = r_yq[r_out_cnt];
    assign bus.out_last  = w_out_valid && (r_out_cnt == 2'd3);
    assign busy          = w_busy;
    assign stateIFFT     = r_state;

endmodule
`default_nettype wire
